crc6_frame_rx: RTL and testbench

- Serial frame receiver that sits directly upstream of the byte-level CRC check stage.
- Deserialises one frame from a bit stream: a start bit, 8 data bits, 6 CRC bits and a stop bit.
- Computes CRC-6 over the data bits serially while they arrive.
- Presents the data byte, the received CRC and the computed CRC with a one-cycle valid strobe for the checker to consume.

---
 rtl/crc6_frame_rx_if.sv | 27 ++
 rtl/crc6_frame_rx.sv | 138 +++++++++++++
 tb/tb_crc6_frame_rx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/crc6_frame_rx_if.sv
// Bundles the serial line inputs and the frame-result outputs of the CRC-6 frame receiver.
interface crc6_frame_rx_if #(
    parameter int DATA_W = 8,
    parameter int CRC_W  = 6
);
    logic              bit_en;
    logic              rx_bit;
    logic [DATA_W-1:0] data_out;
    logic [CRC_W-1:0]  crc_rx;
    logic [CRC_W-1:0]  crc_calc;
    logic              frame_valid;
    logic              crc_err;
    logic              frame_err;
    logic              busy;

    // Upstream side: drives the baud strobe and serial line, observes the results
    modport master (
        output bit_en, rx_bit,
        input  data_out, crc_rx, crc_calc, frame_valid, crc_err, frame_err, busy
    );

    // Receiver side
    modport slave (
        input  bit_en, rx_bit,
        output data_out, crc_rx, crc_calc, frame_valid, crc_err, frame_err, busy
    );
endinterface

// File: rtl/crc6_frame_rx.sv
// Serial frame receiver: start bit, data byte MSB first, CRC-6 field MSB first, stop bit.
// The CRC over the data bits is computed serially as they arrive and presented alongside
// the received CRC field with a one-cycle valid strobe.
module crc6_frame_rx #(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 6,
    parameter logic [CRC_W-1:0] POLY   = 6'h03,
    parameter logic [CRC_W-1:0] INIT   = 6'h37
) (
    input  logic        clk,
    input  logic        rst_n,
    crc6_frame_rx_if.slave bus
);

    localparam int CNT_W = $clog2((DATA_W > CRC_W) ? DATA_W : CRC_W);

    typedef enum logic [2:0] {IDLE, DATA, CRC, STOP, BREAK} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [CNT_W-1:0]   r_bitCnt;
    logic [DATA_W-1:0]  r_dataShift;
    logic [CRC_W-1:0]   r_crcShift;
    logic [CRC_W-1:0]   r_crcCalc;
    logic [DATA_W-1:0]  r_dataOut;
    logic [CRC_W-1:0]   r_crcRxOut;
    logic [CRC_W-1:0]   r_crcCalcOut;
    logic               r_frameValid;
    logic               r_crcErr;
    logic               r_frameErr;

    logic               w_lastData;
    logic               w_lastCrc;
    logic               w_crcFb;
    logic [CRC_W-1:0]   w_crcNext;
    logic               w_busy;
    logic               w_frameGood;
    logic               w_frameBad;

    assign w_lastData = (r_bitCnt == CNT_W'(DATA_W - 1));
    assign w_lastCrc  = (r_bitCnt == CNT_W'(CRC_W - 1));
    assign w_crcFb    = r_crcCalc[CRC_W-1] ^ bus.rx_bit;
    assign w_crcNext  = {r_crcCalc[CRC_W-2:0], 1'b0} ^ (w_crcFb ? POLY : '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; the FSM only advances on baud strobes
    always_comb begin
        w_nextState = r_state;
        if (bus.bit_en) begin
            case (r_state)
                IDLE:    if (!bus.rx_bit) w_nextState = DATA;
                DATA:    if (w_lastData)  w_nextState = CRC;
                CRC:     if (w_lastCrc)   w_nextState = STOP;
                STOP:    w_nextState = bus.rx_bit ? IDLE : BREAK;
                BREAK:   if (bus.rx_bit)  w_nextState = IDLE;
                default: w_nextState = IDLE;
            endcase
        end
    end

    // Decoded state outputs: busy level and the stop-bit verdicts that launch the pulses
    always_comb begin
        w_busy      = (r_state != IDLE);
        w_frameGood = 1'b0;
        w_frameBad  = 1'b0;
        if (bus.bit_en && (r_state == STOP)) begin
            w_frameGood = bus.rx_bit;
            w_frameBad  = !bus.rx_bit;
        end
    end

    // Bit counter, data/CRC shift registers and serial CRC calculator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitCnt    <= '0;
            r_dataShift <= '0;
            r_crcShift  <= '0;
            r_crcCalc   <= '0;
        end else if (bus.bit_en) begin
            case (r_state)
                IDLE: begin
                    r_bitCnt  <= '0;
                    r_crcCalc <= INIT;
                end
                DATA: begin
                    r_dataShift <= {r_dataShift[DATA_W-2:0], bus.rx_bit};
                    r_crcCalc   <= w_crcNext;
                    r_bitCnt    <= w_lastData ? '0 : r_bitCnt + CNT_W'(1);
                end
                CRC: begin
                    r_crcShift <= {r_crcShift[CRC_W-2:0], bus.rx_bit};
                    r_bitCnt   <= w_lastCrc ? '0 : r_bitCnt + CNT_W'(1);
                end
                default: begin
                    r_bitCnt <= '0;
                end
            endcase
        end
    end

    // Result registers update only on a good stop bit; the strobes last one clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dataOut    <= '0;
            r_crcRxOut   <= '0;
            r_crcCalcOut <= '0;
            r_frameValid <= 1'b0;
            r_crcErr     <= 1'b0;
            r_frameErr   <= 1'b0;
        end else begin
            r_frameValid <= w_frameGood;
            r_crcErr     <= w_frameGood && (r_crcShift != r_crcCalc);
            r_frameErr   <= w_frameBad;
            if (w_frameGood) begin
                r_dataOut    <= r_dataShift;
                r_crcRxOut   <= r_crcShift;
                r_crcCalcOut <= r_crcCalc;
            end
        end
    end

    assign bus.data_out    = r_dataOut;
    assign bus.crc_rx      = r_crcRxOut;
    assign bus.crc_calc    = r_crcCalcOut;
    assign bus.frame_valid = r_frameValid;
    assign bus.crc_err     = r_crcErr;
    assign bus.frame_err   = r_frameErr;
    assign bus.busy        = w_busy;

endmodule

// File: tb/tb_crc6_frame_rx.sv
// Self-checking bench for crc6_frame_rx: expected frames are queued when driven and
// compared when the receiver strobes frame_valid.
`timescale 1ns/100ps
module tb_crc6_frame_rx;

    typedef struct packed {
        logic [7:0] data;
        logic [5:0] crcRx;
        logic [5:0] crcCalc;
        logic       crcErr;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cycleCount;
    int   validSeen;
    int   frameErrSeen;
    int   expPushed;
    int   lastValidCycle;
    int   prevValidCycle;
    exp_t expQ[$];

    crc6_frame_rx_if rxIf ();

    crc6_frame_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rxIf.slave)
    );

    // Free-running clock, 10 ns period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time the spacing of frame_valid pulses
    always @(posedge clk) cycleCount++;

    // Reference serial CRC-6, x^6+x+1, seeded with 0x37, data MSB first
    function automatic logic [5:0] crcModel(input logic [7:0] d);
        logic [5:0] c;
        logic       fb;
        c = 6'h37;
        for (int i = 7; i >= 0; i--) begin
            fb = c[5] ^ d[i];
            c  = {c[4:0], 1'b0};
            if (fb) c = c ^ 6'h03;
        end
        return c;
    endfunction

    // Single comparison point: counts the check and reports any difference
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Present one bit after 'gap' idle clocks, then strobe bit_en for one clock
    task automatic sendBit(input logic b, input int gap);
        rxIf.rx_bit = b;
        rxIf.bit_en = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rxIf.bit_en = 1'b1;
        @(posedge clk);
        #1;
        rxIf.bit_en = 1'b0;
    endtask

    // Drive one whole frame; a good stop bit queues the expected result
    task automatic applyStimulus(input logic [7:0] d, input logic [5:0] c, input logic stopBit,
                                 input int gapMin, input int gapMax);
        exp_t e;
        if (stopBit) begin
            e.data    = d;
            e.crcRx   = c;
            e.crcCalc = crcModel(d);
            e.crcErr  = (c != e.crcCalc);
            expQ.push_back(e);
            expPushed++;
        end
        sendBit(1'b0, $urandom_range(gapMax, gapMin));
        for (int i = 7; i >= 0; i--) sendBit(d[i], $urandom_range(gapMax, gapMin));
        for (int i = 5; i >= 0; i--) sendBit(c[i], $urandom_range(gapMax, gapMin));
        sendBit(stopBit, $urandom_range(gapMax, gapMin));
        rxIf.rx_bit = 1'b1;
    endtask

    // Monitor: pops the scoreboard on each frame_valid and watches the pulse rules
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rxIf.frame_valid === 1'b1) begin
                validSeen++;
                prevValidCycle = lastValidCycle;
                lastValidCycle = cycleCount;
                if (expQ.size() == 0) begin
                    checkOutput("spurious_valid", 32'(rxIf.frame_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("data_out", 32'(rxIf.data_out), 32'(e.data));
                    checkOutput("crc_rx",   32'(rxIf.crc_rx),   32'(e.crcRx));
                    checkOutput("crc_calc", 32'(rxIf.crc_calc), 32'(e.crcCalc));
                    checkOutput("crc_err",  32'(rxIf.crc_err),  32'(e.crcErr));
                end
            end else begin
                checkOutput("crc_err_unqualified", 32'(rxIf.crc_err), 32'd0);
            end
            if (rxIf.frame_err === 1'b1) begin
                frameErrSeen++;
                checkOutput("err_with_valid", 32'(rxIf.frame_valid), 32'd0);
            end
        end
    end

    // Directed sequence followed by the randomised frame sweep
    initial begin
        logic [7:0] d;
        logic [5:0] c;
        int         errBefore;
        checks = 0; errors = 0; cycleCount = 0; validSeen = 0;
        frameErrSeen = 0; expPushed = 0; lastValidCycle = 0; prevValidCycle = 0;
        rxIf.bit_en = 1'b0;
        rxIf.rx_bit = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_data_out",    32'(rxIf.data_out),    32'd0);
        checkOutput("rst_crc_rx",      32'(rxIf.crc_rx),      32'd0);
        checkOutput("rst_crc_calc",    32'(rxIf.crc_calc),    32'd0);
        checkOutput("rst_frame_valid", 32'(rxIf.frame_valid), 32'd0);
        checkOutput("rst_frame_err",   32'(rxIf.frame_err),   32'd0);
        checkOutput("rst_busy",        32'(rxIf.busy),        32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] good frame 0x00/0x2B, bit_en every 4 clks");
        applyStimulus(8'h00, 6'h2B, 1'b1, 3, 3);
        checkOutput("busy_after_frame", 32'(rxIf.busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("valid_count_1", 32'(validSeen), 32'd1);

        $display("[TB] bad CRC field 0x2A");
        applyStimulus(8'h00, 6'h2A, 1'b1, 3, 3);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] stop bit 0, line held low, then recovery");
        applyStimulus(8'h5C, 6'h11, 1'b0, 3, 3);
        for (int i = 0; i < 20; i++) sendBit(1'b0, 3);
        checkOutput("break_busy",     32'(rxIf.busy),     32'd1);
        checkOutput("break_data_out", 32'(rxIf.data_out), 32'h00);
        checkOutput("break_crc_rx",   32'(rxIf.crc_rx),   32'h2A);
        checkOutput("break_crc_calc", 32'(rxIf.crc_calc), 32'h2B);
        checkOutput("frame_err_count", 32'(frameErrSeen), 32'd1);
        checkOutput("break_no_valid", 32'(validSeen),     32'd2);
        sendBit(1'b1, 3);
        checkOutput("break_exit_busy", 32'(rxIf.busy), 32'd0);
        applyStimulus(8'h00, 6'h2B, 1'b1, 3, 3);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] 200 random frames with random bit_en gaps");
        for (int n = 0; n < 200; n++) begin
            d = 8'($urandom);
            c = ($urandom_range(1, 0) == 1) ? crcModel(d) : 6'($urandom);
            applyStimulus(d, c, 1'b1, 0, 5);
        end
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] asynchronous reset after the 4th data bit");
        applyStimulus(8'hA5, crcModel(8'hA5), 1'b1, 0, 2);
        repeat (2) @(posedge clk);
        #1;
        sendBit(1'b0, 1);
        for (int i = 0; i < 4; i++) sendBit(1'b1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_data_out", 32'(rxIf.data_out), 32'd0);
        checkOutput("midrst_crc_rx",   32'(rxIf.crc_rx),   32'd0);
        checkOutput("midrst_crc_calc", 32'(rxIf.crc_calc), 32'd0);
        checkOutput("midrst_busy",     32'(rxIf.busy),     32'd0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        rxIf.rx_bit = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(8'h3C, crcModel(8'h3C), 1'b1, 1, 1);
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] back-to-back frames with bit_en every clock");
        errBefore = validSeen;
        applyStimulus(8'hA5, crcModel(8'hA5), 1'b1, 0, 0);
        applyStimulus(8'h00, 6'h2B, 1'b1, 0, 0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("b2b_pulse_count", 32'(validSeen - errBefore), 32'd2);
        checkOutput("b2b_spacing", 32'(lastValidCycle - prevValidCycle), 32'd16);
        checkOutput("b2b_last_data", 32'(rxIf.data_out), 32'h00);

        repeat (20) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("valid_total",   32'(validSeen),   32'(expPushed));
        checkOutput("frame_err_total", 32'(frameErrSeen), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
